// File: rtl/apb_matmul_regif_if.sv
// APB3 slave-side bundle for the matrix-multiply register front-end.
// Signal names keep the _i/_o direction suffixes as seen from the register block.
interface apb_matmul_regif_if #(
  parameter int ADDR_W = 16,
  parameter int BW     = 32,
  parameter int DW     = 8
);
  localparam int MAX_DIM = BW / DW;

  logic               psel_i;
  logic               penable_i;
  logic               pwrite_i;
  logic [MAX_DIM-1:0] pstrb_i;
  logic [ADDR_W-1:0]  paddr_i;
  logic [BW-1:0]      pwdata_i;
  logic [BW-1:0]      prdata_o;
  logic               pready_o;
  logic               pslverr_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_matmul_regif.sv
// APB3 register front-end for the systolic matmul array: operand rows, control,
// overflow flags and scratchpads, plus launch and word-serial result write-back.
module apb_matmul_regif #(
  parameter int DW     = 8,
  parameter int BW     = 32,
  parameter int ADDR_W = 16,
  parameter int SPN    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  apb_matmul_regif_if.slave                    apb,
  input  logic                                 done_i,
  input  logic [(BW/DW)*(BW/DW)-1:0]           of_i,
  input  logic [BW*(BW/DW)*(BW/DW)-1:0]        result_i,
  output logic [BW*(BW/DW)-1:0]                operand_a_o,
  output logic [BW*(BW/DW)-1:0]                operand_b_o,
  output logic [BW*(BW/DW)*(BW/DW)-1:0]        operand_c_o,
  output logic [15:0]                          control_o,
  output logic                                 start_o,
  output logic                                 busy_o
);
  localparam int MAX_DIM = BW / DW;
  localparam int ELEM    = MAX_DIM * MAX_DIM;
  localparam int IDX_W   = ADDR_W - 5;
  localparam int ROW_W   = $clog2(MAX_DIM);
  localparam int WORD_W  = $clog2(ELEM);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, START, WAIT, WB} state_e;

  state_e               apb_st_q, apb_st_d, op_st_q, op_st_d;
  logic [BW-1:0]        opa_q [MAX_DIM], opa_d [MAX_DIM];
  logic [BW-1:0]        opb_q [MAX_DIM], opb_d [MAX_DIM];
  logic [BW-1:0]        sp_q  [SPN][ELEM], sp_d [SPN][ELEM];
  logic [BW-1:0]        wb_buf_q [ELEM], wb_buf_d [ELEM];
  logic [WORD_W-1:0]    wb_cnt_q, wb_cnt_d;
  logic [15:0]          ctrl_q, ctrl_d;
  logic [ELEM-1:0]      flags_q, flags_d;
  logic [BW*ELEM-1:0]   opc_q, opc_d;
  logic                 start_q, start_d, busy_q, busy_d;
  logic                 pready_q, pready_d, pslverr_q, pslverr_d;
  logic [BW-1:0]        prdata_q, prdata_d;

  // Address decode of the live bus
  logic [2:0]           region;
  logic [IDX_W-1:0]     idx;
  logic [ROW_W-1:0]     row;
  logic [WORD_W-1:0]    word;
  logic [1:0]           sp_sel, sp_idx, wb_sp, c_sp;
  logic                 sp_ok, acc_err;
  logic [15:0]          ctrl_new;
  logic [BW-1:0]        rd_data;

  function automatic logic [BW-1:0] merge(input logic [BW-1:0] old_v,
                                          input logic [BW-1:0] wd,
                                          input logic [MAX_DIM-1:0] st);
    logic [BW-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (st[i]) r[i*DW +: DW] = wd[i*DW +: DW];
    end
    return r;
  endfunction

  assign region = apb.paddr_i[4:2];
  assign idx    = apb.paddr_i[ADDR_W-1:5];
  assign row    = idx[ROW_W-1:0];
  assign word   = idx[WORD_W-1:0];
  assign sp_sel = region[1:0];
  assign sp_ok  = ({1'b0, sp_sel} < 3'(SPN));
  assign sp_idx = sp_ok ? sp_sel : 2'd0;
  assign wb_sp  = ctrl_q[3:2];
  assign c_sp   = ctrl_q[5:4];

  always_comb begin
    ctrl_new = ctrl_q;
    for (int i = 0; i < 16 / DW; i++) begin
      if (apb.pstrb_i[i]) ctrl_new[i*DW +: DW] = apb.pwdata_i[i*DW +: DW];
    end
  end

  always_comb begin
    acc_err = 1'b0;
    rd_data = '0;
    case (region)
      3'd0: begin
        acc_err = (idx != '0) ||
                  (apb.pwrite_i && (({1'b0, ctrl_new[3:2]} >= 3'(SPN)) ||
                                    ({1'b0, ctrl_new[5:4]} >= 3'(SPN))));
        rd_data = BW'(ctrl_q);
      end
      3'd1: begin
        acc_err = (idx >= IDX_W'(MAX_DIM));
        rd_data = opa_q[row];
      end
      3'd2: begin
        acc_err = (idx >= IDX_W'(MAX_DIM));
        rd_data = opb_q[row];
      end
      3'd3: begin
        acc_err = (idx != '0) || apb.pwrite_i;
        rd_data = BW'(flags_q);
      end
      default: begin
        acc_err = !sp_ok || (idx >= IDX_W'(ELEM));
        rd_data = sp_q[sp_idx][word];
      end
    endcase
    if (apb.pwrite_i && busy_q) acc_err = 1'b1;
  end

  always_comb begin
    apb_st_d  = apb_st_q;
    op_st_d   = op_st_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sp_d      = sp_q;
    wb_buf_d  = wb_buf_q;
    wb_cnt_d  = wb_cnt_q;
    ctrl_d    = ctrl_q;
    flags_d   = flags_q;
    opc_d     = opc_q;
    start_d   = start_q;
    busy_d    = busy_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;

    // Operation sequencer; the APB sub-FSM below runs alongside it.
    case (op_st_q)
      IDLE: ;
      START: begin
        start_d = 1'b0;
        op_st_d = WAIT;
        for (int k = 0; k < ELEM; k++) begin
          opc_d[BW*k +: BW] = ctrl_q[1] ? sp_q[c_sp][k] : '0;
        end
      end
      WAIT: begin
        if (done_i) begin
          for (int k = 0; k < ELEM; k++) wb_buf_d[k] = result_i[BW*k +: BW];
          flags_d  = of_i;
          wb_cnt_d = '0;
          op_st_d  = WB;
        end
      end
      WB: begin
        sp_d[wb_sp][wb_cnt_q] = wb_buf_q[0];
        for (int k = 0; k < ELEM - 1; k++) wb_buf_d[k] = wb_buf_q[k+1];
        wb_buf_d[ELEM-1] = '0;
        wb_cnt_d = wb_cnt_q + 1'b1;
        if (wb_cnt_q == WORD_W'(ELEM - 1)) begin
          ctrl_d[0] = 1'b0;
          busy_d    = 1'b0;
          op_st_d   = IDLE;
        end
      end
      default: op_st_d = IDLE;
    endcase

    // Writes land on the edge that raises pready, so the response cycle sees them.
    case (apb_st_q)
      IDLE: begin
        if (apb.psel_i && apb.penable_i) begin
          apb_st_d  = ACC1;
          pready_d  = 1'b1;
          pslverr_d = acc_err;
          prdata_d  = (acc_err || apb.pwrite_i) ? '0 : rd_data;
          if (apb.pwrite_i && !acc_err) begin
            case (region)
              3'd0: begin
                ctrl_d = ctrl_new;
                if (ctrl_new[0] && op_st_q == IDLE) begin
                  op_st_d = START;
                  start_d = 1'b1;
                  busy_d  = 1'b1;
                end
              end
              3'd1:    opa_d[row] = merge(opa_q[row], apb.pwdata_i, apb.pstrb_i);
              3'd2:    opb_d[row] = merge(opb_q[row], apb.pwdata_i, apb.pstrb_i);
              3'd3:    ;
              default: sp_d[sp_idx][word] = merge(sp_q[sp_idx][word], apb.pwdata_i, apb.pstrb_i);
            endcase
          end
        end
      end
      ACC1: begin
        apb_st_d  = ACC2;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
      ACC2:    apb_st_d = IDLE;
      default: apb_st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      apb_st_q  <= IDLE;
      op_st_q   <= IDLE;
      opa_q     <= '{default: '0};
      opb_q     <= '{default: '0};
      sp_q      <= '{default: '{default: '0}};
      wb_buf_q  <= '{default: '0};
      wb_cnt_q  <= '0;
      ctrl_q    <= '0;
      flags_q   <= '0;
      opc_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      apb_st_q  <= apb_st_d;
      op_st_q   <= op_st_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sp_q      <= sp_d;
      wb_buf_q  <= wb_buf_d;
      wb_cnt_q  <= wb_cnt_d;
      ctrl_q    <= ctrl_d;
      flags_q   <= flags_d;
      opc_q     <= opc_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_rows
    assign operand_a_o[BW*gi +: BW] = opa_q[gi];
    assign operand_b_o[BW*gi +: BW] = opb_q[gi];
  end

  assign operand_c_o   = opc_q;
  assign control_o     = ctrl_q;
  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign apb.prdata_o  = prdata_q;
  assign apb.pready_o  = pready_q;
  assign apb.pslverr_o = pslverr_q;
endmodule

// File: tb/tb_apb_matmul_regif.sv
// Directed bench for apb_matmul_regif (SPN=3): register table, launch/write-back,
// busy errors, bias latch and mid-operation reset.
module tb_apb_matmul_regif;
  localparam int DW = 8, BW = 32, ADDR_W = 16, SPN = 3;
  localparam int MAX_DIM = BW / DW;
  localparam int ELEM = MAX_DIM * MAX_DIM;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic done_i = 1'b0;
  logic [ELEM-1:0] of_i = '0;
  logic [BW*ELEM-1:0] result_i = '0;
  logic [BW*MAX_DIM-1:0] operand_a_o, operand_b_o;
  logic [BW*ELEM-1:0] operand_c_o;
  logic [15:0] control_o;
  logic start_o, busy_o;

  apb_matmul_regif_if #(.ADDR_W(ADDR_W), .BW(BW), .DW(DW)) bus ();

  apb_matmul_regif #(.DW(DW), .BW(BW), .ADDR_W(ADDR_W), .SPN(SPN)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .apb(bus),
    .done_i(done_i), .of_i(of_i), .result_i(result_i),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .operand_c_o(operand_c_o),
    .control_o(control_o), .start_o(start_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic start_seen;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One APB transfer: setup, enable, response, then the turnaround cycle.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err);
    @(negedge clk_i);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
    bus.paddr_i = addr; bus.pwdata_i = wd; bus.pstrb_i = st;
    @(negedge clk_i);
    bus.penable_i = 1'b1;
    check("pready_first_cycle", bus.pready_o, 1'b0);
    @(negedge clk_i);
    check("pready_response", bus.pready_o, 1'b1);
    rd = bus.prdata_o;
    err = bus.pslverr_o;
    start_seen = start_o;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    @(negedge clk_i);
    check("pready_drop", bus.pready_o, 1'b0);
    $display("[TB] xfer wr=%0d addr=%04h wd=%08h st=%b -> rd=%08h err=%0d", wr, addr, wd, st, rd, err);
  endtask

  task automatic wr_chk(input string nm, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic exp_err);
    logic [31:0] rd; logic err;
    xfer(1'b1, addr, wd, st, rd, err);
    check(nm, err, exp_err);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] rd; logic err;
    xfer(1'b0, addr, 32'h0, 4'h0, rd, err);
    check({nm, "_data"}, rd, exp);
    check({nm, "_err"}, err, exp_err);
  endtask

  // Called one cycle after the START cycle: done_i rises 5 cycles after start_o,
  // then busy_o must stay high for exactly ELEM write-back cycles.
  task automatic finish_op(input int base, input logic [15:0] of_v);
    int cyc;
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    done_i = 1'b1; of_i = of_v;
    for (int k = 0; k < ELEM; k++) result_i[BW*k +: BW] = 32'(base + k);
    @(negedge clk_i);
    done_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 40) begin
      cyc++;
      @(negedge clk_i);
    end
    check("wb_busy_cycles", 32'(cyc), 32'(ELEM));
  endtask

  logic [31:0] rd_v;
  logic err_v;
  logic [BW*ELEM-1:0] exp_c;

  initial begin
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.pstrb_i = '0; bus.paddr_i = '0; bus.pwdata_i = '0;

    vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h000C, 32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0004, 32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h0024, 32'hA1B2C3D4, 4'h5, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0024, 32'h0,        4'h0, 32'h00B200D4, 1'b0});
    vecs.push_back('{1'b0, 16'h001C, 32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h001C, 32'h11111111, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 16'h0084, 32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h000C, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 16'h000C, 32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h0000, 32'h00000008, 4'h3, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 32'h00000008, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 32'h0000000C, 4'h3, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h0000, 32'h00000030, 4'h1, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 32'h00000008, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 32'hFFFFFFC0, 4'h2, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0000FF08, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 32'hFFFF0000, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h0074, 32'h12345678, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0074, 32'h0,        4'h0, 32'h12345678, 1'b0});
    vecs.push_back('{1'b0, 16'h0210, 32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h0048, 32'hDEADBEEF, 4'h8, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0048, 32'h0,        4'h0, 32'hDE000000, 1'b0});
    vecs.push_back('{1'b0, 16'h0118, 32'h0,        4'h0, 32'h0,        1'b0});

    repeat (3) @(negedge clk_i);
    check("reset_outputs", {bus.prdata_o, bus.pready_o, bus.pslverr_o, start_o, busy_o, control_o}, '0);
    check("reset_operands", {operand_a_o, operand_b_o, operand_c_o}, '0);
    reset_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st, rd_v, err_v);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp_rd);
      check($sformatf("vec%0d_pslverr", i), err_v, vecs[i].exp_err);
    end
    check("operand_a_row1", operand_a_o[63:32], 32'h00B200D4);

    // done_i outside WAIT must be ignored
    @(negedge clk_i); done_i = 1'b1; of_i = 16'hFFFF; result_i = '1;
    @(negedge clk_i); done_i = 1'b0;
    check("idle_done_busy", busy_o, 1'b0);
    rd_chk("idle_done_flags", 16'h000C, 32'h0, 1'b0);

    // A = identity, B = diag(2)
    for (int r = 0; r < MAX_DIM; r++) begin
      wr_chk("opa_ident", 16'(16'h0004 + 32 * r), 32'h1 << (8 * r), 4'hF, 1'b0);
      wr_chk("opb_diag",  16'(16'h0008 + 32 * r), 32'h2 << (8 * r), 4'hF, 1'b0);
    end
    check("operand_a_ident", operand_a_o, {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001});
    check("operand_b_diag",  operand_b_o, {32'h02000000, 32'h00020000, 32'h00000200, 32'h00000002});

    // Launch, write back into SP0
    wr_chk("ctrl_start", 16'h0000, 32'h00000001, 4'hF, 1'b0);
    check("start_pulse", start_seen, 1'b1);
    check("start_one_cycle", start_o, 1'b0);
    check("busy_after_start", busy_o, 1'b1);
    check("operand_c_nobias", operand_c_o, '0);
    finish_op(0, 16'hA5C3);
    check("busy_low_after_wb", busy_o, 1'b0);
    check("control_start_cleared", control_o, 16'h0);
    for (int k = 0; k < ELEM; k++) rd_chk($sformatf("sp0_w%0d", k), 16'(16'h0010 + 32 * k), 32'(k), 1'b0);
    rd_chk("flags_after_op", 16'h000C, 32'h0000A5C3, 1'b0);

    // Writes are refused while busy, reads are served
    wr_chk("ctrl_start2", 16'h0000, 32'h00000001, 4'hF, 1'b0);
    wr_chk("busy_opb_write", 16'h0008, 32'hFFFFFFFF, 4'hF, 1'b1);
    rd_chk("busy_flags_read", 16'h000C, 32'h0000A5C3, 1'b0);
    rd_chk("busy_opb_unchanged", 16'h0008, 32'h00000002, 1'b0);
    finish_op(100, 16'h0F0F);
    rd_chk("sp0_w7_op2", 16'h0010 + 16'd224, 32'd107, 1'b0);

    // Bias latch from SP1, then reset during write-back
    for (int k = 0; k < ELEM; k++) begin
      wr_chk("sp1_fill", 16'(16'h0014 + 32 * k), 32'h1000 + 32'(k), 4'hF, 1'b0);
      exp_c[BW*k +: BW] = 32'h1000 + 32'(k);
    end
    wr_chk("ctrl_bias", 16'h0000, 32'h00000013, 4'hF, 1'b0);
    check("bias_start_pulse", start_seen, 1'b1);
    check("operand_c_bias", operand_c_o, exp_c);
    repeat (4) @(negedge clk_i);
    done_i = 1'b1;
    for (int k = 0; k < ELEM; k++) result_i[BW*k +: BW] = 32'(200 + k);
    @(negedge clk_i); done_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("busy_mid_wb", busy_o, 1'b1);
    reset_ni = 1'b0;
    #1;
    check("midop_reset_outputs", {bus.prdata_o, bus.pready_o, bus.pslverr_o, start_o, busy_o, control_o}, '0);
    check("midop_reset_operands", {operand_a_o, operand_b_o, operand_c_o}, '0);
    @(negedge clk_i); reset_ni = 1'b1;
    rd_chk("post_reset_ctrl", 16'h0000, 32'h0, 1'b0);
    rd_chk("post_reset_sp1", 16'h0014, 32'h0, 1'b0);
    wr_chk("ctrl_start3", 16'h0000, 32'h00000001, 4'hF, 1'b0);
    check("post_reset_start", start_seen, 1'b1);
    finish_op(300, 16'h1234);
    rd_chk("post_reset_sp0_w5", 16'h0010 + 16'd160, 32'd305, 1'b0);
    rd_chk("post_reset_flags", 16'h000C, 32'h00001234, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
